rr_arbiter_ctrl: RTL and testbench

Round-robin arbiter and controller for N requesters sharing one resource. It issues a one-hot registered grant, holds it while the owner keeps requesting, and force-releases the grant after MAX_HOLD cycles. Priority rotates through a mask register: after each grant, requesters above the winner get priority. It sits between the requester blocks and the shared resource's enable/select.

---
 rtl/rr_arb_pkg.sv | 29 ++
 rtl/rr_mask_reg.sv | 31 +++
 rtl/rr_arbiter_ctrl.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   state_t         : controller states (IDLE, GRANT, RELEASE)
//   DEF_N           : default requester count
//   DEF_MAX_HOLD    : default maximum consecutive grant cycles
//   MAX_N           : widest request vector the helper function accepts
//   lowest_set_idx  : index of the lowest set bit of a vector (0 if none)
package rr_arb_pkg;

  localparam int DEF_N        = 3;
  localparam int DEF_MAX_HOLD = 8;
  localparam int MAX_N        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Scans from the top down so the last hit is the lowest set index.
  function automatic int lowest_set_idx(input logic [MAX_N-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mask_reg.sv
// Round-robin priority mask register.
//   clk  : clock
//   rst  : synchronous active-high reset, loads all ones
//   en_i : load enable (asserted on a grant edge)
//   d_i  : next mask value
//   q_o  : current mask
module rr_mask_reg #(
  parameter int N = rr_arb_pkg::DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] mask_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else if (en_i) begin
      mask_q <= d_i;
    end
  end

  assign q_o = mask_q;

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter/controller for N requesters sharing one resource.
//   clk       : clock
//   rst       : synchronous active-high reset
//   req_i     : level-sensitive requests, sampled only while idle
//   gnt_o     : registered one-hot grant
//   gnt_id_o  : index of the current grant, holds its last value while idle
//   busy_o    : high while a grant is asserted
//   timeout_o : one-cycle pulse when a grant is force-released after MAX_HOLD
// Every output is a flop; there is no combinational path from req_i.
module rr_arbiter_ctrl #(
  parameter int N        = rr_arb_pkg::DEF_N,
  parameter int MAX_HOLD = rr_arb_pkg::DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  import rr_arb_pkg::*;

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]     GNT_LSB = N'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     mask_q, mask_d;
  logic             mask_en;
  logic [N-1:0]     masked, pick_vec;
  logic [MAX_N-1:0] pick_ext;
  logic [ID_W-1:0]  winner_id;

  // Winner: lowest masked requester, falling back to the lowest raw requester
  // once everyone above the previous winner has had a turn.
  always_comb begin
    masked   = req_i & mask_q;
    pick_vec = (|masked) ? masked : req_i;
    pick_ext = '0;
    pick_ext[N-1:0] = pick_vec;
    winner_id = ID_W'(lowest_set_idx(pick_ext));
  end

  // Priority for the next round: only requesters strictly above the winner.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < N; i++) begin
      mask_d[i] = (i > int'(winner_id));
    end
  end

  rr_mask_reg #(.N(N)) u_mask (
    .clk  (clk),
    .rst  (rst),
    .en_i (mask_en),
    .d_i  (mask_d),
    .q_o  (mask_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    mask_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = GRANT;
          gnt_d    = GNT_LSB << winner_id;
          gnt_id_d = winner_id;
          busy_d   = 1'b1;
          cnt_d    = '0;
          mask_en  = 1'b1;
        end
      end

      GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Request drop is checked first so it masks a simultaneous timeout.
        if (!req_i[gnt_id_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end

      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Self-checking bench for rr_arbiter_ctrl (N=3, MAX_HOLD=4): directed
// scenarios followed by random requests, all compared against a
// cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_ctrl;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N-1:0]    gnt_o;
  logic [ID_W-1:0] gnt_id_o;
  logic            busy_o;
  logic            timeout_o;

  always #5 clk = ~clk;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the resource, how many cycles the grant has
  // been visible, whether we are in the one-cycle cool-down after a
  // release, and who won last (-1 = nobody, i.e. start search from 0).
  int owner;
  int held;
  int last_win;
  int exp_id;
  bit cooling;
  bit exp_to;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Rotating priority: first requester after the last winner, else lowest.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int i = last + 1; i < N; i++) if (r[i]) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rs);
    if (rs) begin
      owner = -1; held = 0; last_win = -1; exp_id = 0;
      cooling = 1'b0; exp_to = 1'b0;
      return;
    end
    exp_to = 1'b0;
    if (owner >= 0) begin
      if (!r[owner]) begin
        owner = -1; cooling = 1'b1;
      end else if (held == MAX_HOLD) begin
        owner = -1; cooling = 1'b1; exp_to = 1'b1;
      end else begin
        held++;
      end
    end else if (cooling) begin
      cooling = 1'b0;
    end else if (r != '0) begin
      owner    = pick(r, last_win);
      held     = 1;
      exp_id   = owner;
      last_win = owner;
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] exp_gnt;
    req_i = r;
    rst   = rs;
    @(posedge clk);
    model_step(r, rs);
    cyc++;
    @(negedge clk);
    exp_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
    check("gnt",     32'(gnt_o),     32'(exp_gnt));
    check("gnt_id",  32'(gnt_id_o),  32'(exp_id));
    check("busy",    32'(busy_o),    32'(owner >= 0));
    check("timeout", 32'(timeout_o), 32'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic         rs;
    owner = -1; held = 0; last_win = -1; exp_id = 0;
    cooling = 1'b0; exp_to = 1'b0;

    // Reset values.
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b1);
    check("rst_gnt",  32'(gnt_o),  32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);

    // All requesting: rotation 001 -> 010 -> 100 -> 001 with forced releases.
    tick(3'b111, 1'b0);
    check("first_gnt", 32'(gnt_o), 32'h1);
    for (int i = 0; i < 24; i++) tick(3'b111, 1'b0);

    // Short ownership, voluntary release leaves mask at 110.
    tick(3'b000, 1'b1);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b000, 1'b0);
    check("drop_gnt", 32'(gnt_o),     32'h0);
    check("drop_to",  32'(timeout_o), 32'h0);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b101, 1'b0);
    check("masked_win", 32'(gnt_o), 32'h4);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b101, 1'b0);
    check("fallback_win", 32'(gnt_o), 32'h1);

    // Owner drops in the very cycle the hold limit is reached.
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b010, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) tick(3'b010, 1'b0);
    tick(3'b000, 1'b0);
    check("edge_drop_gnt", 32'(gnt_o),     32'h0);
    check("edge_drop_to",  32'(timeout_o), 32'h0);

    // Reset in the middle of a grant (counter at 2) restores the mask.
    tick(3'b000, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b1);
    check("midrst_gnt",  32'(gnt_o),     32'h0);
    check("midrst_busy", 32'(busy_o),    32'h0);
    check("midrst_to",   32'(timeout_o), 32'h0);
    tick(3'b011, 1'b0);
    check("post_rst_win", 32'(gnt_o), 32'h1);

    // Short pulse from other requesters while granted is ignored.
    tick(3'b001, 1'b0);
    tick(3'b111, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    check("pulse_ignored", 32'(gnt_o), 32'h0);

    // Random traffic: requests change occasionally so holds and timeouts occur.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      rs = ($urandom_range(0, 99) == 0);
      tick(r, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
